// File: rtl/dlx_dmem_arbiter.sv
// dlx_dmem_arbiter: shares the single-port data SRAM between the uDLX core (absolute priority)
// and a debug/loader requester served in idle memory cycles via req/gnt/ack.
module dlx_dmem_arbiter #(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 32,
  parameter int WAIT_WIDTH = 4,
  parameter int MAX_WAIT   = 15
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  core_rd_en,
  input  logic                  core_wr_en,
  input  logic [ADDR_WIDTH-1:0] core_addr,
  input  logic [DATA_WIDTH-1:0] core_wdata,
  output logic [DATA_WIDTH-1:0] core_rdata,
  input  logic                  dbg_req,
  input  logic                  dbg_we,
  input  logic [ADDR_WIDTH-1:0] dbg_addr,
  input  logic [DATA_WIDTH-1:0] dbg_wdata,
  output logic                  dbg_gnt,
  output logic                  dbg_ack,
  output logic [DATA_WIDTH-1:0] dbg_rdata,
  output logic                  dbg_starve,
  output logic                  mem_rd_en,
  output logic                  mem_wr_en,
  output logic [ADDR_WIDTH-1:0] mem_addr,
  output logic [DATA_WIDTH-1:0] mem_wdata,
  input  logic [DATA_WIDTH-1:0] mem_rdata
);
  typedef enum logic [1:0] {IDLE, DATA, ACK} state_t;
  localparam logic [WAIT_WIDTH-1:0] MAX = WAIT_WIDTH'(MAX_WAIT);
  state_t state, state_next;
  logic core_act, rd_core, dbg_rd;
  logic [WAIT_WIDTH-1:0] wait_cnt, wait_next;
  assign core_act   = core_rd_en | core_wr_en;
  assign dbg_gnt    = (state == IDLE) & dbg_req & ~core_act;
  assign dbg_ack    = (state == ACK);
  assign mem_rd_en  = core_act ? core_rd_en & ~core_wr_en : dbg_gnt & ~dbg_we;
  assign mem_wr_en  = core_act ? core_wr_en : dbg_gnt & dbg_we;
  assign mem_addr   = core_act ? core_addr : dbg_gnt ? dbg_addr : '0;
  assign mem_wdata  = core_act ? core_wdata : dbg_gnt ? dbg_wdata : '0;
  assign core_rdata = rd_core ? mem_rdata : '0;
  always_comb begin
    state_next = (state == IDLE) ? (dbg_gnt ? DATA : IDLE) : (state == DATA) ? ACK : IDLE;
    wait_next  = (dbg_gnt | ~dbg_req) ? '0 :
                 ((state == IDLE) & core_act & (wait_cnt != MAX)) ? wait_cnt + 1'b1 : wait_cnt;
  end
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= IDLE;
      wait_cnt   <= '0;
      rd_core    <= 1'b0;
      dbg_rd     <= 1'b0;
      dbg_starve <= 1'b0;
      dbg_rdata  <= '0;
    end else begin
      state      <= state_next;
      wait_cnt   <= wait_next;
      rd_core    <= core_rd_en & ~core_wr_en;
      dbg_starve <= (wait_next == MAX);
      if (dbg_gnt) dbg_rd <= ~dbg_we;
      // SRAM output during DATA belongs to the debug read issued at grant
      if ((state == DATA) & dbg_rd) dbg_rdata <= mem_rdata;
    end
  end
endmodule
